qspi_xip_ctrl: RTL and testbench

Execute-in-place read sequencer that sits between the instruction-fetch path and QSPI_master's 6-bit register bus.
- Converts each 24-bit flash read request into the register sequence the master needs: write ADR, write CCR with start, wait for busy, poll STA until idle, read DR.
- Returns one 32-bit word per request.
- Arbitrates the master's register bus between itself and a software host port. The host gets access only while the sequencer is idle.

---
 rtl/qspi_xip_ctrl_if.sv | 36 +++
 rtl/qspi_xip_ctrl.sv | 156 +++++++++++++++
 tb/tb_qspi_xip_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/qspi_xip_ctrl_if.sv
// Fetch, response, host and master register-bus signals of the XIP sequencer.
interface qspi_xip_ctrl_if;
    logic        req_valid_i;
    logic [23:0] req_addr_i;
    logic        req_ready_o;
    logic        rsp_valid_o;
    logic [31:0] rsp_data_o;
    logic        rsp_err_o;
    logic        host_write_i;
    logic [3:0]  host_be_i;
    logic [5:0]  host_addr_i;
    logic [31:0] host_wdata_i;
    logic [31:0] host_rdata_o;
    logic        host_stall_o;
    logic        m_write_o;
    logic [3:0]  m_be_o;
    logic [5:0]  m_addr_o;
    logic [31:0] m_wdata_o;
    logic [31:0] m_rdata_i;

    // Sequencer view.
    modport slave (
        input  req_valid_i, req_addr_i, host_write_i, host_be_i, host_addr_i,
               host_wdata_i, m_rdata_i,
        output req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, host_rdata_o,
               host_stall_o, m_write_o, m_be_o, m_addr_o, m_wdata_o
    );

    // Environment view: fetch unit, host and QSPI master together.
    modport master (
        output req_valid_i, req_addr_i, host_write_i, host_be_i, host_addr_i,
               host_wdata_i, m_rdata_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_err_o, host_rdata_o,
               host_stall_o, m_write_o, m_be_o, m_addr_o, m_wdata_o
    );
endinterface

// File: rtl/qspi_xip_ctrl.sv
// Execute-in-place read sequencer: turns a 24-bit fetch into the QSPI master
// register sequence ADR write, CCR start write, STA busy/idle poll, DR read.
module qspi_xip_ctrl #(
    parameter logic [5:0]  PRESCALER = 6'd1,
    parameter logic [7:0]  READ_CMD  = 8'h6B,
    parameter logic [1:0]  DATA_MODE = 2'b11,
    parameter logic [4:0]  DUMMY     = 5'd4,
    parameter logic [15:0] TIMEOUT   = 16'd4095
) (
    input logic             clk_i,
    input logic             rst_ni,
    qspi_xip_ctrl_if.slave  bus
);

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 16;

    localparam logic [AW-1:0] ADDR_CCR = AW'(0);
    localparam logic [AW-1:0] ADDR_ADR = AW'(4);
    localparam logic [AW-1:0] ADDR_DR  = AW'(8);
    localparam logic [AW-1:0] ADDR_STA = AW'(40);

    // Start bit, divider, 4-byte transfer size, dummy count, read, mode, opcode.
    localparam logic [DW-1:0] CCR_WORD = {1'b1, PRESCALER, 4'b0000, 5'd3, DUMMY,
                                          1'b0, DATA_MODE, READ_CMD};

    typedef enum logic [2:0] {
        IDLE, WR_ADR, WR_CCR, WAIT_BUSY, POLL, RD_DR, RESP
    } state_e;

    state_e        state_q;
    logic          ph_q;          // 0: address cycle, 1: sample cycle of a read
    logic [CW-1:0] cnt_q;
    logic          ready_q;
    logic          rsp_valid_q;
    logic          rsp_err_q;
    logic [DW-1:0] rsp_data_q;
    logic          seq_write_q;
    logic [3:0]    seq_be_q;
    logic [AW-1:0] seq_addr_q;
    logic [DW-1:0] seq_wdata_q;

    logic          idle;
    logic          accept;
    logic          sta_idle;
    logic [CW-1:0] cnt_d;
    logic          timed_out;

    // Saturating timeout count and per-cycle decision terms.
    always_comb begin
        idle      = (state_q == IDLE);
        accept    = ready_q & ~bus.host_write_i & bus.req_valid_i;
        sta_idle  = (bus.m_rdata_i == DW'(1));
        cnt_d     = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
        timed_out = (cnt_d >= TIMEOUT);
    end

    // Sequencer FSM with registered master-bus drive and response.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            ph_q        <= 1'b0;
            cnt_q       <= '0;
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            seq_write_q <= 1'b0;
            seq_be_q    <= '0;
            seq_addr_q  <= '0;
            seq_wdata_q <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        state_q     <= WR_ADR;
                        ready_q     <= 1'b0;
                        seq_write_q <= 1'b1;
                        seq_be_q    <= 4'hF;
                        seq_addr_q  <= ADDR_ADR;
                        seq_wdata_q <= {8'h00, bus.req_addr_i};
                    end else begin
                        ready_q <= 1'b1;
                    end
                end
                WR_ADR: begin
                    state_q     <= WR_CCR;
                    seq_addr_q  <= ADDR_CCR;
                    seq_wdata_q <= CCR_WORD;
                end
                WR_CCR: begin
                    state_q     <= WAIT_BUSY;
                    seq_write_q <= 1'b0;
                    seq_be_q    <= '0;
                    seq_addr_q  <= ADDR_STA;
                    seq_wdata_q <= '0;
                    cnt_q       <= '0;
                    ph_q        <= 1'b0;
                end
                WAIT_BUSY, POLL: begin
                    cnt_q <= cnt_d;
                    ph_q  <= ~ph_q;
                    if (timed_out) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b1;
                        rsp_data_q  <= '0;
                        seq_addr_q  <= '0;
                    end else if (ph_q) begin
                        // WAIT_BUSY ignores the stale idle left from before the start write.
                        if (state_q == WAIT_BUSY && !sta_idle) begin
                            state_q <= POLL;
                        end else if (state_q == POLL && sta_idle) begin
                            state_q    <= RD_DR;
                            seq_addr_q <= ADDR_DR;
                        end
                    end
                end
                RD_DR: begin
                    ph_q <= ~ph_q;
                    if (ph_q) begin
                        state_q     <= RESP;
                        rsp_valid_q <= 1'b1;
                        rsp_err_q   <= 1'b0;
                        rsp_data_q  <= bus.m_rdata_i;
                        seq_addr_q  <= '0;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Master bus ownership: host in IDLE, sequencer otherwise; stalled host writes are dropped.
    always_comb begin
        bus.req_ready_o  = idle & ready_q & ~bus.host_write_i;
        bus.host_stall_o = ~idle & bus.host_write_i;
        bus.host_rdata_o = bus.m_rdata_i;
        bus.rsp_valid_o  = rsp_valid_q;
        bus.rsp_err_o    = rsp_err_q;
        bus.rsp_data_o   = rsp_data_q;
        bus.m_write_o    = idle ? bus.host_write_i : seq_write_q;
        bus.m_be_o       = idle ? bus.host_be_i    : seq_be_q;
        bus.m_addr_o     = idle ? bus.host_addr_i  : seq_addr_q;
        bus.m_wdata_o    = idle ? bus.host_wdata_i : seq_wdata_q;
    end

endmodule

// File: tb/tb_qspi_xip_ctrl.sv
// Directed bench for qspi_xip_ctrl with a small QSPI master register model.
module tb_qspi_xip_ctrl;

    localparam logic [31:0] CCR_EXP = 32'h8203_236B;
    localparam int          TO_GAP  = 4096;   // WR_CCR cycle to RESP cycle for TIMEOUT=4095

    logic clk;
    logic rst_n;

    qspi_xip_ctrl_if bus ();

    qspi_xip_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Master model state: 0 = busy 20 cycles after start, 1 = stuck busy, 2 = never busy.
    int          sta_mode  = 0;
    bit          dr_fixed  = 1'b0;
    logic [31:0] dr_val    = 32'h0;
    int          busy_left = 0;
    logic [31:0] adr_lat   = 32'h0;
    logic [31:0] rdata_nxt = 32'h0;
    bit          saw_dr    = 1'b0;
    int          cyc       = 0;
    int          ccr_cyc   = 0;

    logic [37:0] wr_q[$];
    logic [32:0] rsp_q[$];
    int          rsp_cyc_q[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        cyc           <= cyc + 1;
        bus.m_rdata_i <= rdata_nxt;
    end

    // Register model and bus/response monitor, sampled mid-cycle.
    always @(negedge clk) begin
        logic [31:0] nxt;
        case (bus.m_addr_o)
            6'd40:   nxt = (sta_mode == 1) ? 32'd2 :
                           (sta_mode == 2) ? 32'd1 :
                           ((busy_left > 0) ? 32'd2 : 32'd1);
            6'd8:    nxt = dr_fixed ? dr_val : (32'hC0DE_0000 | adr_lat);
            default: nxt = 32'h0;
        endcase
        rdata_nxt = nxt;
        if (bus.m_addr_o == 6'd8) saw_dr = 1'b1;
        if (bus.m_write_o) begin
            wr_q.push_back({bus.m_addr_o, bus.m_wdata_o});
            if (bus.m_addr_o == 6'd4) adr_lat = bus.m_wdata_o;
            if (bus.m_addr_o == 6'd0) ccr_cyc = cyc;
            if (bus.m_addr_o == 6'd0 && bus.m_wdata_o[31]) busy_left = 20;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
        end
        if (bus.rsp_valid_o) begin
            rsp_q.push_back({bus.rsp_err_o, bus.rsp_data_o});
            rsp_cyc_q.push_back(cyc);
        end
    end

    task automatic clear_logs();
        wr_q.delete();
        rsp_q.delete();
        rsp_cyc_q.delete();
        saw_dr = 1'b0;
    endtask

    task automatic issue(input logic [23:0] a);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        bus.req_addr_i  = a;
        bus.req_valid_i = 1'b1;
        for (int k = 0; k < 50 && !ok; k++) begin
            #1;
            if (bus.req_ready_o) ok = 1'b1;
            @(negedge clk);
        end
        bus.req_valid_i = 1'b0;
        chk("accept", 32'(ok), 32'd1);
    endtask

    task automatic wait_rsp(input int n, input int limit);
        for (int k = 0; k < limit && rsp_q.size() < n; k++) @(negedge clk);
        chk("rsp_count", 32'(rsp_q.size()), 32'(n));
    endtask

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_addr_i   = '0;
        bus.host_write_i = 1'b0;
        bus.host_be_i    = '0;
        bus.host_addr_i  = '0;
        bus.host_wdata_i = '0;
        bus.m_rdata_i    = '0;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_ready", 32'(bus.req_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Normal read: ADR/CCR pair, 20 busy cycles, DR returns DEADBEEF.
        sta_mode = 0; dr_fixed = 1'b1; dr_val = 32'hDEAD_BEEF;
        clear_logs();
        issue(24'h12_3456);
        wait_rsp(1, 300);
        repeat (10) @(negedge clk);
        chk("t2_rsp_once", 32'(rsp_q.size()), 32'd1);
        chk("t2_wr_count", 32'(wr_q.size()), 32'd2);
        if (wr_q.size() >= 2) begin
            chk("t2_adr_addr", 32'(wr_q[0][37:32]), 32'd4);
            chk("t2_adr_data", wr_q[0][31:0], 32'h0012_3456);
            chk("t2_ccr_addr", 32'(wr_q[1][37:32]), 32'd0);
            chk("t2_ccr_data", wr_q[1][31:0], CCR_EXP);
        end
        if (rsp_q.size() >= 1) begin
            chk("t2_data", rsp_q[0][31:0], 32'hDEAD_BEEF);
            chk("t2_err", 32'(rsp_q[0][32]), 32'd0);
        end

        // Host write during POLL is stalled, then async reset mid-POLL.
        sta_mode = 1;
        clear_logs();
        issue(24'h00_0100);
        repeat (30) @(negedge clk);
        bus.host_write_i = 1'b1;
        bus.host_addr_i  = 6'd0;
        bus.host_be_i    = 4'hF;
        bus.host_wdata_i = 32'hA5A5_A5A5;
        #1;
        chk("poll_stall", 32'(bus.host_stall_o), 32'd1);
        chk("poll_no_fwd", 32'(bus.m_write_o), 32'd0);
        chk("poll_addr_sta", 32'(bus.m_addr_o), 32'd40);
        @(negedge clk);
        bus.host_write_i = 1'b0;
        bus.host_addr_i  = '0;
        bus.host_be_i    = '0;
        bus.host_wdata_i = '0;
        #1;
        chk("poll_unstall", 32'(bus.host_stall_o), 32'd0);
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_ready", 32'(bus.req_ready_o), 32'd0);
        chk("arst_rsp_valid", 32'(bus.rsp_valid_o), 32'd0);
        chk("arst_rsp_data", bus.rsp_data_o, 32'd0);
        chk("arst_rsp_err", 32'(bus.rsp_err_o), 32'd0);
        chk("arst_stall", 32'(bus.host_stall_o), 32'd0);
        chk("arst_m_write", 32'(bus.m_write_o), 32'd0);
        chk("arst_m_be", 32'(bus.m_be_o), 32'd0);
        chk("arst_m_addr", 32'(bus.m_addr_o), 32'd0);
        chk("arst_m_wdata", bus.m_wdata_o, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        clear_logs();
        repeat (50) @(negedge clk);
        chk("arst_no_rsp", 32'(rsp_q.size()), 32'd0);

        // Host write in IDLE is forwarded and beats a simultaneous request.
        sta_mode = 0; dr_fixed = 1'b0;
        clear_logs();
        @(negedge clk);
        bus.host_write_i = 1'b1;
        bus.host_addr_i  = 6'd0;
        bus.host_be_i    = 4'h3;
        bus.host_wdata_i = 32'h1357_9BDF;
        bus.req_valid_i  = 1'b1;
        bus.req_addr_i   = 24'h00_0040;
        #1;
        chk("idle_fwd_write", 32'(bus.m_write_o), 32'd1);
        chk("idle_fwd_addr", 32'(bus.m_addr_o), 32'd0);
        chk("idle_fwd_be", 32'(bus.m_be_o), 32'h3);
        chk("idle_fwd_wdata", bus.m_wdata_o, 32'h1357_9BDF);
        chk("idle_no_stall", 32'(bus.host_stall_o), 32'd0);
        chk("idle_ready_blocked", 32'(bus.req_ready_o), 32'd0);
        @(negedge clk);
        bus.host_write_i = 1'b0;
        bus.host_addr_i  = '0;
        bus.host_be_i    = '0;
        bus.host_wdata_i = '0;
        #1;
        chk("idle_ready_next", 32'(bus.req_ready_o), 32'd1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        wait_rsp(1, 300);
        if (rsp_q.size() >= 1) begin
            chk("idle_req_data", rsp_q[0][31:0], 32'hC0DE_0040);
            chk("idle_req_err", 32'(rsp_q[0][32]), 32'd0);
        end

        // STA stuck busy: timeout error response TIMEOUT cycles after WR_CCR.
        sta_mode = 1;
        clear_logs();
        issue(24'h00_0200);
        wait_rsp(1, 5000);
        if (rsp_q.size() >= 1) begin
            chk("to_busy_err", 32'(rsp_q[0][32]), 32'd1);
            chk("to_busy_data", rsp_q[0][31:0], 32'd0);
            chk("to_busy_gap", 32'(rsp_cyc_q[0] - ccr_cyc), 32'(TO_GAP));
        end

        // STA never busy: WAIT_BUSY must not fall through to POLL/DR.
        sta_mode = 2;
        clear_logs();
        issue(24'h00_0300);
        wait_rsp(1, 5000);
        chk("to_idle_no_dr", 32'(saw_dr), 32'd0);
        if (rsp_q.size() >= 1) begin
            chk("to_idle_err", 32'(rsp_q[0][32]), 32'd1);
            chk("to_idle_gap", 32'(rsp_cyc_q[0] - ccr_cyc), 32'(TO_GAP));
        end

        // Eight back-to-back requests, responses in order.
        sta_mode = 0; dr_fixed = 1'b0;
        clear_logs();
        for (int i = 0; i < 8; i++) issue(24'(4 * i));
        wait_rsp(8, 2000);
        chk("b2b_wr_count", 32'(wr_q.size()), 32'd16);
        for (int i = 0; i < 8 && i < rsp_q.size(); i++) begin
            chk("b2b_data", rsp_q[i][31:0], 32'hC0DE_0000 | 32'(4 * i));
            chk("b2b_err", 32'(rsp_q[i][32]), 32'd0);
        end
        for (int i = 0; i < 8 && 2 * i + 1 < wr_q.size(); i++) begin
            chk("b2b_adr", wr_q[2*i], {6'd4, 32'(4 * i)});
            chk("b2b_ccr", wr_q[2*i+1], {6'd0, CCR_EXP});
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
